// File: rtl/digital_lock_pkg.sv
// Shared definitions for the parametrised digital lock: state encoding and width helpers.
package digital_lock_pkg;

    localparam logic [1:0] UNLOCKED    = 2'd0;
    localparam logic [1:0] SET_CONFIRM = 2'd1;
    localparam logic [1:0] LOCKED      = 2'd2;
    localparam logic [1:0] LOCKOUT     = 2'd3;

    typedef enum logic [1:0] {
        StUnlocked   = UNLOCKED,
        StSetConfirm = SET_CONFIRM,
        StLocked     = LOCKED,
        StLockout    = LOCKOUT
    } state_e;

    // Smallest r with 2**r >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Bits needed to hold one key index; never narrower than one bit.
    function automatic int unsigned digit_w(input int unsigned key_count);
        return (key_count > 2) ? clog2(key_count) : 1;
    endfunction

endpackage

// File: rtl/digital_lock_lockout_if.sv
// Keypad / status bundle between the keypad side (master) and the lock core (slave).
interface digital_lock_lockout_if
    import digital_lock_pkg::*;
#(
    parameter int unsigned KEY_COUNT       = 4,
    parameter int unsigned PASSCODE_LENGTH = 4
);
    localparam int unsigned COUNT_W = clog2(PASSCODE_LENGTH + 1);

    logic [KEY_COUNT-1:0] key;
    logic                 locked;
    logic                 error;
    logic                 lockout;
    logic [COUNT_W-1:0]   digit_count;
    logic [3:0]           attempts;

    modport master (output key, input locked, error, lockout, digit_count, attempts);
    modport slave  (input key, output locked, error, lockout, digit_count, attempts);

endinterface

// File: rtl/key_capture.sv
// Keypad front end: registers the key levels, detects a new press on the OR of all keys,
// encodes the one-hot level to an index and flags multi-key presses as invalid.
module key_capture
    import digital_lock_pkg::*;
#(
    parameter int unsigned KEY_COUNT = 4,
    parameter int unsigned DIGIT_W   = digit_w(KEY_COUNT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [KEY_COUNT-1:0] key,
    output logic                 valid,
    output logic [DIGIT_W-1:0]   digit,
    output logic                 bad
);
    logic [KEY_COUNT-1:0] key_q;
    logic                 any_q;

    // Sample keys, and remember whether any key was down one cycle earlier.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_q <= '0;
            any_q <= 1'b0;
        end else begin
            key_q <= key;
            any_q <= |key_q;
        end
    end

    // One-cycle strobe on the rising edge; a held level does not repeat.
    assign valid = (|key_q) & ~any_q;
    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign bad   = |(key_q & (key_q - KEY_COUNT'(1)));

    // Index of the set bit (highest wins when several are set; such presses are marked bad).
    always_comb begin
        digit = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (key_q[i]) digit = DIGIT_W'(i);
        end
    end

endmodule

// File: rtl/digital_lock_lockout.sv
// Digital lock with set-by-double-entry, inter-key timeout, failed-attempt counter and
// timed lockout. Optional MASTER_CODE_EN adds a master code that clears LOCKED/LOCKOUT.
module digital_lock_lockout
    import digital_lock_pkg::*;
#(
    parameter int unsigned KEY_COUNT       = 4,
    parameter int unsigned PASSCODE_LENGTH = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 250000000,
    parameter int unsigned MAX_ATTEMPTS    = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 1500000000
`ifdef MASTER_CODE_EN
    ,
    parameter logic [PASSCODE_LENGTH*digit_w(KEY_COUNT)-1:0] MASTER_CODE = '0
`endif
) (
    input logic                   clock,
    input logic                   reset,
    digital_lock_lockout_if.slave bus
);
    localparam int unsigned DIGIT_W = digit_w(KEY_COUNT);
    localparam int unsigned CODE_W  = PASSCODE_LENGTH * DIGIT_W;
    localparam int unsigned COUNT_W = clog2(PASSCODE_LENGTH + 1);
    localparam int unsigned TMO_W   = clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LOCK_W  = clog2(LOCKOUT_CYCLES + 1);

    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(PASSCODE_LENGTH);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCKOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [CODE_W-1:0]    entry_q, entry_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic                 bad_q, bad_d;
    logic                 error_q, error_d;
    logic [3:0]           attempts_q, attempts_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [LOCK_W-1:0]    lock_q, lock_d;

    logic                 key_valid;
    logic [DIGIT_W-1:0]   key_digit;
    logic                 key_bad;
    logic                 cap_en, entry_done, tmo_run, tmo_expire, capture, lock_done;
    logic                 code_match;
    logic [3:0]           attempts_inc;

    key_capture #(
        .KEY_COUNT (KEY_COUNT),
        .DIGIT_W   (DIGIT_W)
    ) u_key_capture (
        .clock (clock),
        .reset (reset),
        .key   (bus.key),
        .valid (key_valid),
        .digit (key_digit),
        .bad   (key_bad)
    );

`ifdef MASTER_CODE_EN
    logic master_match;
    assign master_match = (entry_q == MASTER_CODE) && !bad_q;
    // Keys stay live in LOCKOUT so the master code can be entered there.
    assign cap_en = 1'b1;
`else
    assign cap_en = (state_q != StLockout);
`endif

    assign entry_done   = (count_q == COUNT_FULL);
    assign tmo_run      = (count_q != '0) && !entry_done;
    assign tmo_expire   = tmo_run && (tmo_q == TMO_LAST);
    // Expiry beats a simultaneous press; the verdict cycle does not take new digits.
    assign capture      = key_valid && cap_en && !entry_done && !tmo_expire;
    assign lock_done    = (state_q == StLockout) && (lock_q == LOCK_LAST);
    assign code_match   = (entry_q == code_q) && !bad_q;
    assign attempts_inc = (attempts_q == 4'hF) ? attempts_q : attempts_q + 4'd1;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StUnlocked;
            count_q    <= '0;
            entry_q    <= '0;
            code_q     <= '0;
            bad_q      <= 1'b0;
            error_q    <= 1'b0;
            attempts_q <= '0;
            tmo_q      <= '0;
            lock_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            entry_q    <= entry_d;
            code_q     <= code_d;
            bad_q      <= bad_d;
            error_q    <= error_d;
            attempts_q <= attempts_d;
            tmo_q      <= tmo_d;
            lock_q     <= lock_d;
        end
    end

    // Next state: timers, digit capture, timeout and the verdict one cycle after completion.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        entry_d    = entry_q;
        code_d     = code_q;
        bad_d      = bad_q;
        error_d    = error_q;
        attempts_d = attempts_q;
        tmo_d      = tmo_q;
        lock_d     = lock_q;

        if (tmo_run && (tmo_q != TMO_LAST)) tmo_d = tmo_q + TMO_W'(1);
        if ((state_q == StLockout) && (lock_q != LOCK_LAST)) lock_d = lock_q + LOCK_W'(1);

        // Lockout expiry first so a same-cycle master verdict below can still override it.
        if (lock_done) begin
            state_d    = StLocked;
            attempts_d = '0;
            lock_d     = '0;
        end

        if (tmo_expire) begin
            count_d = '0;
            entry_d = '0;
            bad_d   = 1'b0;
            tmo_d   = '0;
            if (state_q == StSetConfirm) begin
                state_d = StUnlocked;
                code_d  = '0;
            end
        end else if (capture) begin
            for (int i = 0; i < PASSCODE_LENGTH; i++) begin
                if (count_q == COUNT_W'(i)) entry_d[i*DIGIT_W +: DIGIT_W] = key_digit;
            end
            bad_d   = bad_q | key_bad;
            count_d = count_q + COUNT_W'(1);
            error_d = 1'b0;
            tmo_d   = '0;
        end else if (entry_done) begin
            count_d = '0;
            entry_d = '0;
            bad_d   = 1'b0;
            tmo_d   = '0;
            unique case (state_q)
                StUnlocked: begin
                    // An invalid first entry is never stored as a code.
                    if (bad_q) begin
                        error_d = 1'b1;
                    end else begin
                        code_d  = entry_q;
                        state_d = StSetConfirm;
                    end
                end
                StSetConfirm: begin
                    if (code_match) begin
                        state_d = StLocked;
                        error_d = 1'b0;
                    end else begin
                        state_d = StUnlocked;
                        error_d = 1'b1;
                        code_d  = '0;
                    end
                end
                StLocked: begin
`ifdef MASTER_CODE_EN
                    if (master_match) begin
                        state_d    = StUnlocked;
                        attempts_d = '0;
                        error_d    = 1'b0;
                    end else
`endif
                    if (code_match) begin
                        state_d    = StUnlocked;
                        attempts_d = '0;
                    end else begin
                        error_d    = 1'b1;
                        attempts_d = attempts_inc;
                        if ({28'd0, attempts_inc} >= MAX_ATTEMPTS) begin
                            state_d = StLockout;
                            lock_d  = '0;
                        end
                    end
                end
                StLockout: begin
`ifdef MASTER_CODE_EN
                    // Anything but the master code is dropped without a trace.
                    if (master_match) begin
                        state_d    = StUnlocked;
                        attempts_d = '0;
                        error_d    = 1'b0;
                        lock_d     = '0;
                    end
`endif
                end
            endcase
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        bus.locked      = (state_q == StLocked) || (state_q == StLockout);
        bus.lockout     = (state_q == StLockout);
        bus.error       = error_q;
        bus.digit_count = count_q;
        bus.attempts    = attempts_q;
    end

endmodule
